// File: rtl/pc_sequencer.sv
// pc_sequencer: RV32IM fetch sequencer producing PC_Next/PCWrite with boot, divide stall, imem wait and halt
module pc_sequencer #(
    parameter int PC_WIDTH    = 32,
    parameter int PC_STEP     = 4,
    parameter int BOOT_CYCLES = 2,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                CPU_clk,
    input  logic                CPU_rst_n,
    input  logic [PC_WIDTH-1:0] PC,
    input  logic                Branch_Taken,
    input  logic                Jump,
    input  logic [PC_WIDTH-1:0] Target_Addr,
    input  logic                Div_Op,
    input  logic                Halt_Req,
    input  logic                Imem_Ready,
    output logic [PC_WIDTH-1:0] PC_Next,
    output logic                PCWrite,
    output logic                Div_Start,
    output logic                Div_Busy,
    output logic                Halted,
    output logic                Misaligned_Fetch
);
    localparam int BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam int DW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {BOOT, RUN, DIV, HALT} state_t;

    state_t        state, state_n;
    logic [BW-1:0] boot_cnt, boot_cnt_n;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic          div_done, div_done_n;
    logic          mis_n;
    logic          redirect;

    assign redirect = Branch_Taken | Jump;
    assign Div_Busy = (state == DIV);
    assign Halted   = (state == HALT);

    // state and counter registers; reset aborts any boot, divide or stall in progress
    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            state            <= BOOT;
            boot_cnt         <= BW'(BOOT_CYCLES);
            div_cnt          <= '0;
            div_done         <= 1'b0;
            Misaligned_Fetch <= 1'b0;
        end else begin
            state            <= state_n;
            boot_cnt         <= boot_cnt_n;
            div_cnt          <= div_cnt_n;
            div_done         <= div_done_n;
            Misaligned_Fetch <= mis_n;
        end
    end

    // next-state and PC control: halt > misaligned redirect > divide launch > imem stall > advance
    always_comb begin
        state_n    = state;
        boot_cnt_n = boot_cnt;
        div_cnt_n  = div_cnt;
        div_done_n = div_done;
        mis_n      = Misaligned_Fetch;
        PCWrite    = 1'b0;
        PC_Next    = PC;
        Div_Start  = 1'b0;
        case (state)
            BOOT: begin
                if (boot_cnt != '0) begin
                    boot_cnt_n = boot_cnt - 1'b1;
                end else begin
                    PCWrite = 1'b1;
                    PC_Next = PC + PC_WIDTH'(PC_STEP);
                    state_n = RUN;
                end
            end
            RUN: begin
                if (Halt_Req) begin
                    state_n = HALT;
                end else if (redirect && Target_Addr[1:0] != 2'b00) begin
                    mis_n   = 1'b1;
                    state_n = HALT;
                end else if (Div_Op && !div_done) begin
                    Div_Start = 1'b1;
                    div_cnt_n = DW'(DIV_CYCLES - 1);
                    state_n   = DIV;
                end else if (Imem_Ready) begin
                    PCWrite    = 1'b1;
                    PC_Next    = redirect ? Target_Addr : PC + PC_WIDTH'(PC_STEP);
                    div_done_n = 1'b0;
                end
            end
            DIV: begin
                if (div_cnt == '0) begin
                    div_done_n = 1'b1;
                    state_n    = RUN;
                end else begin
                    div_cnt_n = div_cnt - 1'b1;
                end
            end
            default: state_n = HALT;
        endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus against a cycle-level behavioural model plus literal spot checks
module tb_pc_sequencer;
    localparam int BOOT_N = 2;
    localparam int DIV_N  = 4;

    logic        CPU_clk = 1'b0;
    logic        CPU_rst_n = 1'b0;
    logic [31:0] PC, Target_Addr, PC_Next;
    logic        Branch_Taken, Jump, Div_Op, Halt_Req, Imem_Ready;
    logic        PCWrite, Div_Start, Div_Busy, Halted, Misaligned_Fetch;

    int checks = 0;
    int errors = 0;

    // model state: edges since reset release, boot done, halted, trapped, remaining divide cycles, divide result ready
    int          m_t, m_div_left;
    bit          m_booted, m_halt, m_mis, m_done;
    logic [31:0] m_pc;
    logic [31:0] e_next;
    logic        e_we, e_start;

    assign PC = m_pc;

    pc_sequencer #(.PC_WIDTH(32), .PC_STEP(4), .BOOT_CYCLES(BOOT_N), .DIV_CYCLES(DIV_N)) dut (
        .CPU_clk(CPU_clk), .CPU_rst_n(CPU_rst_n), .PC(PC), .Branch_Taken(Branch_Taken),
        .Jump(Jump), .Target_Addr(Target_Addr), .Div_Op(Div_Op), .Halt_Req(Halt_Req),
        .Imem_Ready(Imem_Ready), .PC_Next(PC_Next), .PCWrite(PCWrite), .Div_Start(Div_Start),
        .Div_Busy(Div_Busy), .Halted(Halted), .Misaligned_Fetch(Misaligned_Fetch)
    );

    always #5 CPU_clk = ~CPU_clk;

    // what the sequencer must present this cycle
    always_comb begin
        e_next  = m_pc;
        e_we    = 1'b0;
        e_start = 1'b0;
        if (!CPU_rst_n) begin
            e_we = 1'b0;
        end else if (!m_booted) begin
            if (m_t == BOOT_N) begin
                e_we   = 1'b1;
                e_next = m_pc + 32'd4;
            end
        end else if (!m_halt && m_div_left == 0 && !Halt_Req &&
                     !((Branch_Taken || Jump) && Target_Addr[1:0] != 2'b00)) begin
            if (Div_Op && !m_done) begin
                e_start = 1'b1;
            end else if (Imem_Ready) begin
                e_we   = 1'b1;
                e_next = (Branch_Taken || Jump) ? Target_Addr : m_pc + 32'd4;
            end
        end
    end

    // model progression and the PC register the sequencer controls
    always @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            m_t <= 0; m_div_left <= 0; m_booted <= 0; m_halt <= 0; m_mis <= 0; m_done <= 0;
            m_pc <= 32'hFFFF_FFFC;
        end else begin
            if (e_we) m_pc <= e_next;
            if (!m_booted) begin
                if (m_t == BOOT_N) m_booted <= 1; else m_t <= m_t + 1;
            end else if (m_halt) begin
                m_halt <= 1;
            end else if (m_div_left > 0) begin
                m_div_left <= m_div_left - 1;
                if (m_div_left == 1) m_done <= 1;
            end else if (Halt_Req) begin
                m_halt <= 1;
            end else if ((Branch_Taken || Jump) && Target_Addr[1:0] != 2'b00) begin
                m_halt <= 1; m_mis <= 1;
            end else if (e_start) begin
                m_div_left <= DIV_N;
            end else if (e_we) begin
                m_done <= 0;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge CPU_clk) begin
        chk("pc_next", PC_Next, e_next);
        chk("pcwrite", 32'(PCWrite), 32'(e_we));
        chk("div_start", 32'(Div_Start), 32'(e_start));
        chk("div_busy", 32'(Div_Busy), 32'(m_div_left > 0));
        chk("halted", 32'(Halted), 32'(m_halt));
        chk("misaligned", 32'(Misaligned_Fetch), 32'(m_mis));
    end

    task automatic rst();
        CPU_rst_n = 1'b0;
        {Branch_Taken, Jump, Div_Op, Halt_Req} = '0;
        Target_Addr = '0;
        Imem_Ready = 1'b1;
        repeat (2) @(posedge CPU_clk);
        #1 CPU_rst_n = 1'b1;
        @(negedge CPU_clk);
    endtask

    task automatic cyc(input logic br, input logic jp, input logic [31:0] tgt,
                       input logic dv, input logic hl, input logic im);
        @(posedge CPU_clk);
        #1;
        Branch_Taken = br; Jump = jp; Target_Addr = tgt; Div_Op = dv; Halt_Req = hl; Imem_Ready = im;
        @(negedge CPU_clk);
    endtask

    task automatic boot();
        rst();
        chk("boot_c1_we", 32'(PCWrite), 0);
        cyc(0, 1, 32'h2, 1, 1, 0);
        chk("boot_c2_we", 32'(PCWrite), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("boot_c3_we", 32'(PCWrite), 1);
        chk("boot_c3_next", PC_Next, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        boot();
        cyc(0, 1, 32'h100, 0, 0, 1);
        chk("jump_next", PC_Next, 32'h100);
        chk("jump_we", 32'(PCWrite), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("seq_next", PC_Next, 32'h104);
        cyc(0, 0, 0, 0, 0, 0);
        chk("stall_next", PC_Next, 32'h104);
        chk("stall_we", 32'(PCWrite), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("seq2_next", PC_Next, 32'h108);
        cyc(1, 0, 32'h40, 0, 0, 1);
        chk("branch_next", PC_Next, 32'h40);
        chk("branch_we", 32'(PCWrite), 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("div_launch_start", 32'(Div_Start), 1);
        chk("div_launch_we", 32'(PCWrite), 0);
        for (int i = 0; i < DIV_N; i++) begin
            cyc(0, 0, 0, 1, 0, 1);
            chk("div_busy_lit", 32'(Div_Busy), 1);
            chk("div_no_restart", 32'(Div_Start), 0);
        end
        cyc(0, 0, 0, 1, 0, 0);
        chk("div_stall_we", 32'(PCWrite), 0);
        chk("div_stall_start", 32'(Div_Start), 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("div_done_we", 32'(PCWrite), 1);
        chk("div_done_next", PC_Next, 32'h44);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("div2_start", 32'(Div_Start), 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        #2 CPU_rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(Div_Busy), 0);
        chk("async_we", 32'(PCWrite), 0);
        chk("async_start", 32'(Div_Start), 0);
        chk("async_next", PC_Next, 32'hFFFF_FFFC);
        boot();
        cyc(0, 1, 32'h202, 1, 1, 1);
        chk("halt_prio_start", 32'(Div_Start), 0);
        chk("halt_prio_we", 32'(PCWrite), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("halt_next_halted", 32'(Halted), 1);
        chk("halt_not_mis", 32'(Misaligned_Fetch), 0);
        boot();
        cyc(1, 0, 32'h42, 0, 0, 1);
        chk("mis_we", 32'(PCWrite), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("mis_flag", 32'(Misaligned_Fetch), 1);
        chk("mis_halted", 32'(Halted), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'h40, 1, 0, 1);
            chk("mis_hold", 32'(Misaligned_Fetch), 1);
            chk("mis_hold_we", 32'(PCWrite), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
